fifo_ptr_ctrl: RTL
==================

Name: fifo_ptr_ctrl

Overview:
Single-clock FIFO pointer/flag controller that sequences write and read pointers for an external 2^ADDR_LEN-entry dual-port RAM. It arbitrates producer/consumer requests against full/empty and drives the RAM write enable and addresses. It also exports gray-coded pointers (ADDR_LEN+1 bits) so a later dual-clock variant can synchronise them unchanged. It sits between the multiply datapath's result producer and its consumer.

Parameters:
ADDR_LEN, 4, RAM address width; DEPTH = 2^ADDR_LEN entries
AF_MARGIN, 2, almost_full asserts when occupancy >= DEPTH - AF_MARGIN
AE_MARGIN, 2, almost_empty asserts when occupancy <= AE_MARGIN

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
flush  in  1  synchronous empty-the-FIFO command
wr_req  in  1  producer write request
wr_ack  out  1  write accepted this cycle (combinational)
wr_en  out  1  RAM write enable (equals wr_ack)
wr_addr  out  ADDR_LEN  RAM write address
rd_req  in  1  consumer read request
rd_ack  out  1  read accepted this cycle (combinational)
rd_addr  out  ADDR_LEN  RAM read address
wr_ptr_gray  out  ADDR_LEN+1  registered gray write pointer
rd_ptr_gray  out  ADDR_LEN+1  registered gray read pointer
count  out  ADDR_LEN+1  registered occupancy, 0..DEPTH
full, empty, almost_full, almost_empty  out  1 each  registered flags
overflow, underflow  out  1 each  sticky error flags
clear_err  in  1  synchronous clear of the sticky error flags

Behaviour:
- Reset (async, any time including mid-transfer): binary and gray pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0. With reset asserted, wr_ack = rd_ack = 0.
- Internal binary pointers wb and rb are ADDR_LEN+1 bits. wr_addr = wb[ADDR_LEN-1:0]; rd_addr = rb[ADDR_LEN-1:0].
- Gray outputs are registered and always equal b ^ (b >> 1) of the current binary pointer. They update on the same edge as the binary pointer. There is no extra stage of lag.
- Acceptance:
  - wr_ack = wr_req & ~full & ~flush.
  - rd_ack = rd_req & ~empty & ~flush.
  - Both depend only on registered flags, so there is no combinational path from the request inputs to the flag outputs.
- On an edge with wr_ack, wb increments by 1, wrapping modulo 2^(ADDR_LEN+1). The RAM captures write data at wr_addr on that same edge.
- On an edge with rd_ack, rb increments by 1. RAM read data is valid the cycle after rd_ack; the consumer handles this.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- When full and both requests arrive: the read is accepted, the write is refused. When empty and both arrive: the write is accepted, the read is refused. Neither case deadlocks.
- Flags are computed from next-state pointers (wb_next, rb_next) and registered, so they are exact in the cycle after the accepting edge:
  - empty: wr_gray_next == rd_gray_next.
  - full: gray pointers differ in the two MSBs and match in the remaining bits.
  - count_next = wb_next - rb_next, modulo 2^(ADDR_LEN+1).
  - almost_full: count_next >= DEPTH - AF_MARGIN.
  - almost_empty: count_next <= AE_MARGIN.
- Errors:
  - overflow sets on any edge with wr_req & full.
  - underflow sets on any edge with rd_req & empty.
  - clear_err clears both; a set condition in the same cycle wins.
  - The error flags do not affect pointer operation.
- flush: on the edge, wb = rb = 0, gray pointers = 0, count = 0, empty = almost_empty = 1, full = almost_full = 0. Any requests in that cycle are refused. Sticky error flags are preserved.
- Wrap-around: after 2^(ADDR_LEN+1) writes and reads, the pointers return to 0. The flags stay correct across the wrap because the MSB disambiguates full from empty.

Test Plan:
- Reset, then 16 back-to-back writes, no reads (ADDR_LEN=4):
  - wr_addr 0..15.
  - count 1..16.
  - almost_full rises after the 14th write.
  - full = 1 after the 16th write.
  - A 17th wr_req gives wr_ack = 0 and overflow = 1.
- From full, 16 reads:
  - rd_addr 0..15.
  - empty = 1 after the 16th read.
  - A further rd_req gives rd_ack = 0 and underflow = 1.
  - clear_err then drops both error flags.
- Continuous simultaneous wr_req/rd_req for 40 cycles starting from 1 entry:
  - count stays 1.
  - Pointers wrap past 31 to 0.
  - wr_ptr_gray steps 00000, 00001, 00011, 00010, ..., exactly one bit change per accepted write.
- Full plus simultaneous wr_req & rd_req: rd_ack = 1, wr_ack = 0, count goes 16 to 15. Empty plus both requests: wr_ack = 1, rd_ack = 0, count goes 0 to 1.
- After 5 writes:
  - Assert reset asynchronously mid-cycle: outputs return to reset values before the next edge.
  - Repeat with 5 writes and flush instead: count = 0 and empty = 1 after the edge, error flags retained.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr_ctrl
// Purpose  : Single-clock FIFO pointer/flag controller for an external
//            2^ADDR_LEN-entry dual-port RAM. It accepts or refuses requests,
//            drives the RAM addresses, keeps registered flags and occupancy,
//            and exports gray pointers ready for a dual-clock variant.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl #(
  parameter int ADDR_LEN  = 4,   // RAM address width; must be 2 or more
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                wr_req,
  output logic                wr_ack,
  output logic                wr_en,
  output logic [ADDR_LEN-1:0] wr_addr,
  input  logic                rd_req,
  output logic                rd_ack,
  output logic [ADDR_LEN-1:0] rd_addr,
  output logic [ADDR_LEN:0]   wr_ptr_gray,
  output logic [ADDR_LEN:0]   rd_ptr_gray,
  output logic [ADDR_LEN:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow,
  input  logic                clear_err
);

  localparam int PW    = ADDR_LEN + 1;
  localparam int DEPTH = 1 << ADDR_LEN;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);
  localparam logic [PW-1:0] AE_THRESH = PW'(AE_MARGIN);
  // Gray pointers one full lap apart differ exactly in their two MSBs.
  localparam logic [PW-1:0] FULL_XOR  = PW'(3) << (PW - 2);

  logic [PW-1:0] wb_q, wb_d, rb_q, rb_d;
  logic [PW-1:0] wg_q, wg_d, rg_q, rg_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          af_q, af_d, ae_q, ae_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  // Acceptance uses only registered flags; reset forces both acks low.
  always_comb begin
    wr_ack = wr_req & ~full_q  & ~flush & ~reset;
    rd_ack = rd_req & ~empty_q & ~flush & ~reset;
  end

  // Next-state pointers, gray codes, occupancy, flags and sticky errors.
  always_comb begin
    wb_d = wb_q;
    rb_d = rb_q;
    if (flush) begin
      wb_d = '0;
      rb_d = '0;
    end else begin
      wb_d = wb_q + {{(PW-1){1'b0}}, wr_ack};
      rb_d = rb_q + {{(PW-1){1'b0}}, rd_ack};
    end
    wg_d    = wb_d ^ (wb_d >> 1);
    rg_d    = rb_d ^ (rb_d >> 1);
    count_d = wb_d - rb_d;
    empty_d = (wg_d == rg_d);
    full_d  = ((wg_d ^ rg_d) == FULL_XOR);
    af_d    = (count_d >= AF_THRESH);
    ae_d    = (count_d <= AE_THRESH);
    // A new error in the same cycle takes priority over clear_err.
    ovf_d   = (wr_req & full_q)  | (ovf_q & ~clear_err);
    unf_d   = (rd_req & empty_q) | (unf_q & ~clear_err);
  end

  // State register with asynchronous clear to the empty condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q    <= '0;
      rb_q    <= '0;
      wg_q    <= '0;
      rg_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      wg_q    <= wg_d;
      rg_q    <= rg_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Output mapping; RAM addresses are the low bits of the binary pointers.
  always_comb begin
    wr_en        = wr_ack;
    wr_addr      = wb_q[ADDR_LEN-1:0];
    rd_addr      = rb_q[ADDR_LEN-1:0];
    wr_ptr_gray  = wg_q;
    rd_ptr_gray  = rg_q;
    count        = count_q;
    full         = full_q;
    empty        = empty_q;
    almost_full  = af_q;
    almost_empty = ae_q;
    overflow     = ovf_q;
    underflow    = unf_q;
  end

endmodule
`default_nettype wire
